rst_seq_ctrl: RTL and testbench

Reset and clock-enable sequencer for the testbench/DUT clock resource.
- Takes the free-running clk and a raw asynchronous reset.
- Releases NUM_DOM domain resets in a fixed, staggered order, with each domain's clock enable running before its reset drops.
- After initial bring-up, serves per-domain software reset requests via a req/ack handshake, one domain at a time.

---
 rtl/rst_seq_pkg.sv | 18 +
 rtl/rst_sync.sv | 24 ++
 rtl/rst_seq_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staggered reset / clock-enable sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    HOLD  = 3'd1,
    REL   = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4,
    SWRST = 3'd5
  } rst_seq_state_e;

  // Index width for n domains; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset-release synchronizer: clears asynchronously, reports release only after
// SYNC_STAGES clean clock edges.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_released
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift chain filling with ones once reset is gone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_released = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staggered domain reset release after power-on, then one-at-a-time software
// domain resets over a level-request / pulse-ack handshake.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DOM-1:0] sw_rst_req,
  output logic [NUM_DOM-1:0] sw_rst_ack,
  output logic [NUM_DOM-1:0] dom_rst,
  output logic [NUM_DOM-1:0] dom_clk_en,
  output logic               seq_done,
  output logic               busy
);

  localparam int               IDX_W     = idx_width(NUM_DOM);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOM - 1);

  if (NUM_DOM < 1 || NUM_DOM > 16) begin : g_bad_num_dom
    $error("rst_seq_ctrl: NUM_DOM must be within 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_seq_ctrl: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_hold
    $error("rst_seq_ctrl: HOLD_CYCLES must be >= 1 and fit in CNT_W");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_gap
    $error("rst_seq_ctrl: GAP_CYCLES must fit in CNT_W");
  end

  rst_seq_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [IDX_W-1:0]   r_sw_idx, w_sw_idx_nxt;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [NUM_DOM-1:0] r_dom_rst, w_dom_rst_nxt;
  logic [NUM_DOM-1:0] r_clk_en, w_clk_en_nxt;
  logic [NUM_DOM-1:0] r_ack, w_ack_nxt;
  logic               r_seq_done, w_seq_done_nxt;
  logic               r_busy, w_busy_nxt;
  logic               w_released;
  logic               w_grant_any;
  logic               w_hold_last;
  logic               w_gap_last;
  logic               w_rel_fire;
  logic               w_rel_last;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .i_clk     (clk),
    .i_rst     (rst),
    .o_released(w_released)
  );

  assign w_hold_last = (r_cnt == HOLD_LAST);
  assign w_gap_last  = (r_cnt == GAP_LAST);
  // HOLD releases domain 0 on its terminal edge; REL releases on every edge.
  assign w_rel_fire  = (r_state == REL) || ((r_state == HOLD) && w_hold_last);
  assign w_rel_last  = (r_idx == LAST_IDX);
  assign w_grant_any = |sw_rst_req;

  // Fixed-priority pick of the lowest pending request.
  always_comb begin
    w_grant_idx = {IDX_W{1'b0}};
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (sw_rst_req[i]) begin
        w_grant_idx = IDX_W'(i);
      end else begin
        w_grant_idx = w_grant_idx;
      end
    end
  end

  // State, shared counter and domain indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= SYNC;
      r_cnt    <= {CNT_W{1'b0}};
      r_idx    <= {IDX_W{1'b0}};
      r_sw_idx <= {IDX_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_sw_idx <= w_sw_idx_nxt;
    end
  end

  // Next-state logic; the counter restarts at zero on every state entry.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_idx_nxt    = r_idx;
    w_sw_idx_nxt = r_sw_idx;
    case (r_state)
      SYNC: begin
        w_cnt_nxt = {CNT_W{1'b0}};
        if (w_released) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = SYNC;
        end
      end
      HOLD, REL: begin
        if (w_rel_fire) begin
          w_cnt_nxt = {CNT_W{1'b0}};
          if (w_rel_last) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = (GAP_CYCLES == 0) ? REL : GAP;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      GAP: begin
        if (w_gap_last) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = REL;
        end else begin
          w_state_nxt = GAP;
        end
      end
      DONE: begin
        w_cnt_nxt = {CNT_W{1'b0}};
        if (w_grant_any) begin
          w_state_nxt  = SWRST;
          w_sw_idx_nxt = w_grant_idx;
        end else begin
          w_state_nxt = DONE;
        end
      end
      SWRST: begin
        if (w_hold_last) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SWRST;
        end
      end
      default: begin
        w_state_nxt = SYNC;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_idx_nxt   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_dom_rst_nxt  = r_dom_rst;
    w_clk_en_nxt   = r_clk_en;
    w_ack_nxt      = {NUM_DOM{1'b0}};
    w_seq_done_nxt = r_seq_done;
    w_busy_nxt     = r_busy;
    case (r_state)
      SYNC: begin
        if (w_released) begin
          w_clk_en_nxt = {NUM_DOM{1'b1}};
        end else begin
          w_clk_en_nxt = r_clk_en;
        end
      end
      HOLD, REL: begin
        if (w_rel_fire) begin
          w_dom_rst_nxt[r_idx] = 1'b0;
          if (w_rel_last) begin
            w_seq_done_nxt = 1'b1;
            w_busy_nxt     = 1'b0;
          end else begin
            w_busy_nxt = 1'b1;
          end
        end else begin
          w_busy_nxt = r_busy;
        end
      end
      DONE: begin
        if (w_grant_any) begin
          w_dom_rst_nxt[w_grant_idx] = 1'b1;
          w_busy_nxt                 = 1'b1;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      SWRST: begin
        if (w_hold_last) begin
          w_dom_rst_nxt[r_sw_idx] = 1'b0;
          w_ack_nxt[r_sw_idx]     = 1'b1;
          w_busy_nxt              = 1'b0;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_busy_nxt = r_busy;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dom_rst  <= {NUM_DOM{1'b1}};
      r_clk_en   <= {NUM_DOM{1'b0}};
      r_ack      <= {NUM_DOM{1'b0}};
      r_seq_done <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_dom_rst  <= w_dom_rst_nxt;
      r_clk_en   <= w_clk_en_nxt;
      r_ack      <= w_ack_nxt;
      r_seq_done <= w_seq_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign dom_rst    = r_dom_rst;
  assign dom_clk_en = r_clk_en;
  assign sw_rst_ack = r_ack;
  assign seq_done   = r_seq_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: three parameterisations against a
// timeline-based reference model.
module tb_rst_seq_ctrl;

  logic       clk   = 1'b0;
  logic       t_rst = 1'b1;
  logic [3:0] t_req = 4'b0000;

  logic [3:0] ack0, rst0, en0, ack1, rst1, en1, ack2, rst2, en2;
  logic       done0, busy0, done1, busy1, done2, busy2;

  rst_seq_ctrl #(.NUM_DOM(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(4), .CNT_W(8)) u_dut_def (
    .clk(clk), .rst(t_rst), .sw_rst_req(t_req), .sw_rst_ack(ack0),
    .dom_rst(rst0), .dom_clk_en(en0), .seq_done(done0), .busy(busy0));

  rst_seq_ctrl #(.NUM_DOM(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(0), .CNT_W(8)) u_dut_gap0 (
    .clk(clk), .rst(t_rst), .sw_rst_req(t_req), .sw_rst_ack(ack1),
    .dom_rst(rst1), .dom_clk_en(en1), .seq_done(done1), .busy(busy1));

  rst_seq_ctrl #(.NUM_DOM(4), .SYNC_STAGES(2), .HOLD_CYCLES(1), .GAP_CYCLES(4), .CNT_W(8)) u_dut_hold1 (
    .clk(clk), .rst(t_rst), .sw_rst_req(t_req), .sw_rst_ack(ack2),
    .dom_rst(rst2), .dom_clk_en(en2), .seq_done(done2), .busy(busy2));

  always #5 clk = ~clk;

  // Observed vector layout: {ack[3:0], dom_rst[3:0], clk_en[3:0], seq_done, busy}
  localparam logic [13:0] RST_VEC = {4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1};

  int          sel = 0;
  logic [13:0] obs;
  always_comb begin
    case (sel)
      1:       obs = {ack1, rst1, en1, done1, busy1};
      2:       obs = {ack2, rst2, en2, done2, busy2};
      default: obs = {ack0, rst0, en0, done0, busy0};
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: edge number since reset release plus one outstanding grant.
  int          m_s = 2, m_h = 16, m_g = 4, m_n = 4;
  int          m_e, m_k, m_end;
  bit          m_active;
  logic [3:0]  m_ack;
  logic [13:0] m_exp;

  function automatic int t_rel(input int i);
    return m_s + 1 + m_h + i * (m_g + 1);
  endfunction

  task automatic model_eval();
    logic [3:0] dr, en;
    bit dn;
    for (int i = 0; i < 4; i++) dr[i] = (m_e < t_rel(i));
    if (m_active) dr[m_k] = 1'b1;
    en = (m_e >= m_s + 1) ? 4'hF : 4'h0;
    dn = (m_e >= t_rel(m_n - 1));
    m_exp = {m_ack, dr, en, dn, (!dn) || m_active};
  endtask

  task automatic model_reset();
    m_e = 0; m_active = 0; m_k = 0; m_end = 0; m_ack = 4'b0000;
    model_eval();
  endtask

  task automatic model_edge(input logic [3:0] req);
    m_e++;
    m_ack = 4'b0000;
    if (m_active && m_e == m_end) begin
      m_ack[m_k] = 1'b1;
      m_active   = 0;
    end else if (!m_active && m_e > t_rel(m_n - 1) && req != 4'b0000) begin
      for (int i = m_n - 1; i >= 0; i--) if (req[i]) m_k = i;
      m_active = 1;
      m_end    = m_e + m_h;
    end
    model_eval();
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(t_req);
    @(negedge clk);
  endtask

  task automatic start(input int s, input int h, input int g);
    sel = s; m_h = h; m_g = g; t_req = 4'b0000;
    @(negedge clk);
    t_rst = 1'b1;
    @(negedge clk);
    t_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    t_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_tests++;
      if (obs !== RST_VEC) begin
        n_fail++;
        $display("FAIL reset dut=%0d got=%h exp=%h", s, obs, RST_VEC);
      end
    end
  endtask

  task automatic test_power_on();
    start(0, 16, 4);
    for (int c = 0; c < 40; c++) begin
      step();
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL power_on edge=%0d got=%h exp=%h", m_e, obs, m_exp);
      end
    end
  endtask

  task automatic test_gap0();
    start(1, 16, 0);
    for (int c = 0; c < 30; c++) begin
      step();
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL gap0 edge=%0d got=%h exp=%h", m_e, obs, m_exp);
      end
    end
    n_tests++;
    if (obs[1] !== 1'b1 || obs[9:6] !== 4'b0000) begin
      n_fail++;
      $display("FAIL gap0_done got=%h exp_done=1 exp_rst=0", obs);
    end
  endtask

  task automatic test_async_rst();
    start(0, 16, 4);
    for (int c = 0; c < 26; c++) begin
      step();
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL async_pre edge=%0d got=%h exp=%h", m_e, obs, m_exp);
      end
    end
    t_rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== RST_VEC) begin
      n_fail++;
      $display("FAIL async_now got=%h exp=%h", obs, RST_VEC);
    end
    #2;
    t_rst = 1'b0;
    model_reset();
    for (int c = 0; c < 40; c++) begin
      step();
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL async_restart edge=%0d got=%h exp=%h", m_e, obs, m_exp);
      end
    end
  endtask

  task automatic test_two_req();
    logic [3:0] served;
    served = 4'b0000;
    start(0, 16, 4);
    for (int c = 0; c < 90; c++) begin
      if (c == 40) t_req = 4'b0110;
      step();
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL two_req edge=%0d got=%h exp=%h", m_e, obs, m_exp);
      end
      served = served | obs[13:10];
      t_req  = t_req & ~m_ack;
    end
    n_tests++;
    if (served !== 4'b0110) begin
      n_fail++;
      $display("FAIL two_req_served got=%b exp=%b", served, 4'b0110);
    end
  endtask

  task automatic test_req_during_seq();
    start(0, 16, 4);
    for (int c = 0; c < 60; c++) begin
      if (c == 9) t_req = 4'b1000;
      step();
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL early_req edge=%0d got=%h exp=%h", m_e, obs, m_exp);
      end
      if (m_e == 35 || m_e == 51) begin
        n_tests++;
        if ((m_e == 35 && obs[9] !== 1'b1) || (m_e == 51 && obs[13] !== 1'b1)) begin
          n_fail++;
          $display("FAIL early_req_timing edge=%0d got=%h", m_e, obs);
        end
      end
      t_req = t_req & ~m_ack;
    end
  endtask

  task automatic test_hold1();
    logic prev_ack;
    prev_ack = 1'b0;
    start(2, 1, 4);
    t_req = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      step();
      n_tests++;
      if (obs !== m_exp || (prev_ack && obs[10])) begin
        n_fail++;
        $display("FAIL hold1 edge=%0d got=%h exp=%h", m_e, obs, m_exp);
      end
      prev_ack = obs[10];
    end
  endtask

  task automatic test_random();
    start(0, 16, 4);
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(3) == 0) t_req = t_req | 4'($urandom_range(15));
      if ($urandom_range(15) == 0) t_req = t_req & 4'($urandom_range(15));
      step();
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL random edge=%0d req=%b got=%h exp=%h", m_e, t_req, obs, m_exp);
      end
      t_req = t_req & ~m_ack;
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_gap0();
    test_async_rst();
    test_two_req();
    test_req_during_seq();
    test_hold1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
